setup_hold_strobe_gen: RTL and testbench

//  Drives the D/EN inputs of a downstream enable-gated capture register (Q <= D when EN at posedge).

---
 rtl/setup_hold_strobe_gen.sv | 127 ++++++++++++
 tb/tb_setup_hold_strobe_gen.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/setup_hold_strobe_gen.sv
// -----------------------------------------------------------------------------
// setup_hold_strobe_gen
//
// Feeds the D/EN pins of a downstream enable-gated capture register
// (Q <= D when EN at posedge). Each word accepted over a valid/ready handshake
// is placed on d_out and held stable for SETUP_CYC cycles before a single-cycle
// en_out strobe. It stays stable for HOLD_CYC cycles after the strobe, so the
// downstream setup/hold windows are met by construction.
//
// Parameters
//   WIDTH      data width of in_data / d_out
//   SETUP_CYC  cycles d_out is stable before en_out rises (>= 1)
//   HOLD_CYC   cycles d_out is stable after en_out falls (>= 0)
//
// Ports
//   clk       in   1      clock, all state changes on posedge
//   rst_n     in   1      asynchronous active-low reset
//   in_valid  in   1      upstream word available
//   in_data   in   WIDTH  upstream word
//   in_ready  out  1      high in IDLE; transfer when in_valid & in_ready
//   flush     in   1      synchronous abort of the word in flight
//   d_out     out  WIDTH  data to the downstream D input
//   en_out    out  1      one-cycle capture strobe to the downstream EN input
//   busy      out  1      high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module setup_hold_strobe_gen #(
  parameter int WIDTH     = 4,
  parameter int SETUP_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             flush,
  output logic [WIDTH-1:0] d_out,
  output logic             en_out,
  output logic             busy
);

  // Parameter legality is checked at elaboration time.
  if (SETUP_CYC < 1) begin : g_bad_setup
    $error("setup_hold_strobe_gen: SETUP_CYC must be >= 1");
  end
  if (HOLD_CYC < 0) begin : g_bad_hold
    $error("setup_hold_strobe_gen: HOLD_CYC must be >= 0");
  end

  localparam int MAX_CYC = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  // Counters are loaded with N-1 so that a phase lasts exactly N cycles:
  // the phase ends on the edge where the counter is already zero.
  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam bit               HAS_HOLD   = (HOLD_CYC > 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] d_out_q, d_out_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    d_out_d = d_out_q;
    case (state_q)
      IDLE: begin
        // flush wins over a simultaneous in_valid: nothing is accepted.
        if (in_valid && !flush) begin
          d_out_d = in_data;
          cnt_d   = SETUP_LOAD;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (flush)              state_d = IDLE;
        else if (cnt_q == '0)   state_d = STROBE;
        else                    cnt_d   = cnt_q - CNT_ONE;
      end
      STROBE: begin
        // The strobe cycle itself is never shortened: en_out is decoded from
        // state_q, so a flush here only skips the HOLD phase.
        if (flush || !HAS_HOLD) begin
          state_d = IDLE;
        end else begin
          state_d = HOLD;
          cnt_d   = HOLD_LOAD;
        end
      end
      HOLD: begin
        if (flush)              state_d = IDLE;
        else if (cnt_q == '0)   state_d = IDLE;
        else                    cnt_d   = cnt_q - CNT_ONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      d_out_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d_out_q <= d_out_d;
    end
  end

  // All outputs decode registered state only; no input reaches an output
  // combinationally.
  assign in_ready = (state_q == IDLE);
  assign en_out   = (state_q == STROBE);
  assign busy     = (state_q != IDLE);
  assign d_out    = d_out_q;

endmodule

// File: tb/tb_setup_hold_strobe_gen.sv
// -----------------------------------------------------------------------------
// tb_setup_hold_strobe_gen
//
// Directed bench for setup_hold_strobe_gen. Instance u_a uses the default
// parameters (SETUP_CYC=2, HOLD_CYC=1); instance u_b uses HOLD_CYC=0 for the
// back-to-back throughput scenario. A simple downstream capture register is
// modelled per instance to count real captures.
// -----------------------------------------------------------------------------
module tb_setup_hold_strobe_gen;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;

  logic         a_in_valid, a_in_ready, a_flush, a_en_out, a_busy;
  logic [W-1:0] a_in_data, a_d_out;
  logic         b_in_valid, b_in_ready, b_flush, b_en_out, b_busy;
  logic [W-1:0] b_in_data, b_d_out;

  int vectors = 0;
  int errors  = 0;

  // Downstream enable-gated capture registers.
  logic [W-1:0] a_cap_q = '0;
  int           a_cap_cnt = 0;
  int           b_cap_cnt = 0;

  setup_hold_strobe_gen #(.WIDTH(W), .SETUP_CYC(2), .HOLD_CYC(1)) u_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (a_in_valid),
    .in_data  (a_in_data),
    .in_ready (a_in_ready),
    .flush    (a_flush),
    .d_out    (a_d_out),
    .en_out   (a_en_out),
    .busy     (a_busy)
  );

  setup_hold_strobe_gen #(.WIDTH(W), .SETUP_CYC(2), .HOLD_CYC(0)) u_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (b_in_valid),
    .in_data  (b_in_data),
    .in_ready (b_in_ready),
    .flush    (b_flush),
    .d_out    (b_d_out),
    .en_out   (b_en_out),
    .busy     (b_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (a_en_out) begin
      a_cap_q   <= a_d_out;
      a_cap_cnt <= a_cap_cnt + 1;
    end
    if (b_en_out) b_cap_cnt <= b_cap_cnt + 1;
  end

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n      = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_flush = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_flush = 1'b0;
    tick();
    tick();
    vectors++;
    if ({a_d_out, a_en_out, a_in_ready, a_busy} !== {4'h0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_a d/en/rdy/busy got %h/%b/%b/%b want 0/0/1/0",
               a_d_out, a_en_out, a_in_ready, a_busy);
    end
    vectors++;
    if ({b_d_out, b_en_out, b_in_ready, b_busy} !== {4'h0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_b d/en/rdy/busy got %h/%b/%b/%b want 0/0/1/0",
               b_d_out, b_en_out, b_in_ready, b_busy);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if ({a_d_out, a_en_out, a_in_ready, a_busy, b_en_out, b_busy} !==
          {4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL reset_idle cyc %0d a d/en/rdy/busy %h/%b/%b/%b b en/busy %b/%b want 0/0/1/0 0/0",
                 i, a_d_out, a_en_out, a_in_ready, a_busy, b_en_out, b_busy);
      end
    end
    $display("reset released, idle checked");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_single_word();
    bit [4:0] en_tab, rdy_tab, busy_tab;
    en_tab   = 5'b00100;   // en_out high after edge k+2 only
    rdy_tab  = 5'b10000;   // in_ready back after edge k+4
    busy_tab = 5'b01111;
    a_in_valid = 1'b1;
    a_in_data  = 4'hA;
    tick();                // accept edge k
    $display("accept a data=%h", 4'hA);
    a_in_valid = 1'b0;
    a_in_data  = 4'hF;     // must be ignored while busy
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      vectors++;
      if ({a_d_out, a_en_out, a_in_ready, a_busy} !==
          {4'hA, en_tab[i], rdy_tab[i], busy_tab[i]}) begin
        errors++;
        $display("FAIL single k+%0d d/en/rdy/busy got %h/%b/%b/%b want a/%b/%b/%b",
                 i, a_d_out, a_en_out, a_in_ready, a_busy,
                 en_tab[i], rdy_tab[i], busy_tab[i]);
      end
    end
    a_in_data = 4'h0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_back_to_back();
    int          cap0;
    logic [W-1:0] exp_d;
    logic         exp_en, exp_rdy;
    cap0       = b_cap_cnt;
    b_in_valid = 1'b1;
    b_in_data  = 4'h3;
    for (int c = 0; c < 14; c++) begin
      tick();
      // Hand-derived schedule: accepts at edges 0, 4, 8 (period 4).
      exp_d   = (c < 4) ? 4'h3 : (c < 8) ? 4'h5 : 4'h9;
      exp_en  = ((c % 4) == 2) && (c < 12);
      exp_rdy = ((c % 4) == 3) || (c >= 11);
      vectors++;
      if ({b_d_out, b_en_out, b_in_ready, b_busy} !== {exp_d, exp_en, exp_rdy, ~exp_rdy}) begin
        errors++;
        $display("FAIL b2b edge %0d d/en/rdy/busy got %h/%b/%b/%b want %h/%b/%b/%b",
                 c, b_d_out, b_en_out, b_in_ready, b_busy, exp_d, exp_en, exp_rdy, ~exp_rdy);
      end
      if (c == 0 || c == 4 || c == 8) $display("accept b data=%h at edge %0d", exp_d, c);
      if (c == 0) b_in_data = 4'h5;
      if (c == 4) b_in_data = 4'h9;
      if (c == 8) b_in_valid = 1'b0;
    end
    vectors++;
    if (b_cap_cnt - cap0 !== 3) begin
      errors++;
      $display("FAIL b2b_pulses got %0d want 3", b_cap_cnt - cap0);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_flush_setup();
    a_in_valid = 1'b1;
    a_in_data  = 4'h6;
    tick();                // edge 0: accept
    $display("accept a data=%h then flush", 4'h6);
    vectors++;
    if ({a_d_out, a_busy} !== {4'h6, 1'b1}) begin
      errors++;
      $display("FAIL fsetup_acc d/busy got %h/%b want 6/1", a_d_out, a_busy);
    end
    a_in_valid = 1'b0;
    a_flush    = 1'b1;
    tick();                // edge 1: flushed to IDLE
    vectors++;
    if ({a_d_out, a_en_out, a_in_ready, a_busy} !== {4'h6, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL fsetup_idle d/en/rdy/busy got %h/%b/%b/%b want 6/0/1/0",
               a_d_out, a_en_out, a_in_ready, a_busy);
    end
    a_flush    = 1'b0;
    a_in_valid = 1'b1;
    a_in_data  = 4'h7;
    tick();                // edge 2: next word accepted
    $display("accept a data=%h", 4'h7);
    vectors++;
    if ({a_d_out, a_en_out, a_busy} !== {4'h7, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL fsetup_next d/en/busy got %h/%b/%b want 7/0/1", a_d_out, a_en_out, a_busy);
    end
    a_in_valid = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      tick();
      vectors++;
      if ({a_en_out, a_in_ready} !== {(j == 2), (j == 4)}) begin
        errors++;
        $display("FAIL fsetup_drain +%0d en/rdy got %b/%b want %b/%b",
                 j, a_en_out, a_in_ready, (j == 2), (j == 4));
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_flush_strobe();
    a_in_valid = 1'b1;
    a_in_data  = 4'h9;
    tick();                // edge 0
    $display("accept a data=%h, flush in strobe", 4'h9);
    a_in_valid = 1'b0;
    tick();                // edge 1
    tick();                // edge 2: strobe cycle
    a_flush = 1'b1;
    vectors++;
    if ({a_en_out, a_d_out} !== {1'b1, 4'h9}) begin
      errors++;
      $display("FAIL fstrobe_en got en=%b d=%h want 1/9", a_en_out, a_d_out);
    end
    #7;                    // just before edge 3: strobe must still be high
    vectors++;
    if (a_en_out !== 1'b1) begin
      errors++;
      $display("FAIL fstrobe_full en got %b want 1", a_en_out);
    end
    tick();                // edge 3: HOLD skipped
    a_flush = 1'b0;
    vectors++;
    if ({a_d_out, a_en_out, a_in_ready, a_busy} !== {4'h9, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL fstrobe_idle d/en/rdy/busy got %h/%b/%b/%b want 9/0/1/0",
               a_d_out, a_en_out, a_in_ready, a_busy);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_async_reset_hold();
    int cap0;
    cap0       = a_cap_cnt;
    a_in_valid = 1'b1;
    a_in_data  = 4'hB;
    tick();                // edge 0
    $display("accept a data=%h, async reset in hold", 4'hB);
    a_in_valid = 1'b0;
    tick();
    tick();
    tick();                // edge 3: in HOLD
    vectors++;
    if ({a_en_out, a_in_ready, a_busy} !== {1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL areset_hold en/rdy/busy got %b/%b/%b want 0/0/1",
               a_en_out, a_in_ready, a_busy);
    end
    #3 rst_n = 1'b0;
    #1;                    // still well before the next posedge
    vectors++;
    if ({a_d_out, a_en_out, a_in_ready, a_busy} !== {4'h0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL areset_now d/en/rdy/busy got %h/%b/%b/%b want 0/0/1/0",
               a_d_out, a_en_out, a_in_ready, a_busy);
    end
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if ({a_en_out, a_in_ready} !== {1'b0, 1'b1}) begin
        errors++;
        $display("FAIL areset_after cyc %0d en/rdy got %b/%b want 0/1", i, a_en_out, a_in_ready);
      end
    end
    vectors++;
    if ((a_cap_cnt - cap0 !== 1) || (a_cap_q !== 4'hB)) begin
      errors++;
      $display("FAIL areset_caps got count %0d value %h want 1 and b", a_cap_cnt - cap0, a_cap_q);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_flush_setup();
    test_flush_strobe();
    test_async_reset_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
